// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and state encoding shared by the ALU execute stage
package alu_pkg;

    // Op codes, shared with the ALU control decoder
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Execute stage occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    // MUL is the only multi-cycle op; everything else goes through the mux
    function automatic logic is_multicycle(input logic [2:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, low WIDTH bits of a*b
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_last;

    // Partial-product add for the current iteration
    always_comb begin
        w_addend = r_mplier[0] ? r_mcand : '0;
        w_sum    = r_acc + w_addend;
        w_last   = (r_count == CNT_W'(WIDTH - 1));
    end

    // The final iteration's sum is handed out directly so the product lands
    // in the same edge as the WIDTH-th iteration, not one edge later
    assign o_busy    = r_busy;
    assign o_done    = r_busy & w_last;
    assign o_product = w_sum;

    // Latch operands on start, then one shift-add step per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: op mux, sequential MUL, output register
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [TAG_W-1:0] r_tag;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic [WIDTH-1:0] w_alu;
    logic             w_slt;

    // Ready depends only on occupancy and downstream ready, never on in_valid
    always_comb begin
        in_ready = (r_state == ST_EMPTY) | ((r_state == ST_FULL) & out_ready);
    end

    assign w_accept    = in_valid & in_ready;
    assign w_is_mul    = is_multicycle(alu_op);
    assign w_mul_start = w_accept & w_is_mul;

    assign out_valid = (r_state == ST_FULL);
    assign result    = r_result;
    assign zero      = r_zero;
    assign out_tag   = r_tag;
    assign busy      = w_mul_busy;

    // Single-cycle op mux; MUL results come from the iterator instead
    always_comb begin
        w_slt = ($signed(op_a) < $signed(op_b));
        w_alu = '0;
        case (alu_op)
            OP_PASS: w_alu = op_b;
            OP_ADD:  w_alu = op_a + op_b;
            OP_SUB:  w_alu = op_a - op_b;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            OP_AND:  w_alu = op_a & op_b;
            OP_OR:   w_alu = op_a | op_b;
            OP_XOR:  w_alu = op_a ^ op_b;
            default: w_alu = '0;
        endcase
    end

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (op_a),
        .i_b       (op_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // Occupancy FSM with the held result, zero flag and tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_tag    <= '0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_FULL: begin
                    if (w_accept) begin
                        r_tag <= in_tag;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_state  <= ST_FULL;
                        end
                    end else if ((r_state == ST_FULL) && out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_result <= w_mul_product;
                        r_zero   <= (w_mul_product == '0);
                        r_state  <= ST_FULL;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alu_op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic [TW-1:0] out_tag;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_stage #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: what each op means arithmetically, modulo 2^32
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        case (op)
            3'd0: return b;
            3'd1: begin p = longint'(a) + longint'(b); return p[W-1:0]; end
            3'd2: begin p = longint'(a) - longint'(b); return p[W-1:0]; end
            3'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: begin p = longint'(a) * longint'(b); return p[W-1:0]; end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // One full transaction with optional downstream stall, checked against ref_alu
    task automatic txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag, input int stall);
        logic [W-1:0] exp;
        int n;
        exp = ref_alu(op, a, b);
        out_ready = 1'b1;
        present(op, a, b, tag);
        check("txn_in_ready", in_ready, 1);
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick;
            n++;
        end
        check("txn_latency", n, (op == OP_MUL) ? W : 0);
        check("txn_result", result, exp);
        check("txn_zero", zero, (exp == 0) ? 1 : 0);
        check("txn_tag", out_tag, tag);
        for (int s = 0; s < stall; s++) begin
            tick;
            check("txn_hold_result", result, exp);
            check("txn_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        check("txn_drain", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rop;
        int           cnt;
        int           bad;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        alu_op = 3'd0;
        op_a = '0;
        op_b = '0;
        in_tag = '0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // ADD 5+7, latency 1, then idle
        out_ready = 1'b1;
        present(OP_ADD, 5, 7, 3);
        tick;
        in_valid = 1'b0;
        check("add_valid", out_valid, 1);
        check("add_result", result, 12);
        check("add_zero", zero, 0);
        check("add_tag", out_tag, 3);
        tick;
        check("add_idle", out_valid, 0);

        txn(OP_SUB, 9, 9, 4, 0);
        txn(OP_SLT, 32'hFFFF_FFFF, 1, 5, 1);
        txn(OP_SLT, 1, 32'hFFFF_FFFF, 6, 0);

        // Back-to-back AND, OR, XOR
        out_ready = 1'b1;
        present(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 10);
        tick;
        check("b2b_and", result, 32'h00F0_1234);
        check("b2b_rdy1", in_ready, 1);
        present(OP_OR, 32'hF000_0001, 32'h0000_0F10, 11);
        tick;
        check("b2b_or", result, 32'hF000_0F11);
        check("b2b_rdy2", in_ready, 1);
        present(OP_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF, 12);
        tick;
        in_valid = 1'b0;
        check("b2b_xor", result, 32'h5555_AAAA);
        check("b2b_tag", out_tag, 12);
        check("b2b_valid", out_valid, 1);
        tick;
        check("b2b_idle", out_valid, 0);

        // Directed MUL
        present(OP_MUL, 32'h0001_0003, 32'h0000_0005, 13);
        tick;
        in_valid = 1'b0;
        cnt = 0;
        bad = 0;
        while (!out_valid && cnt < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            tick;
            cnt++;
        end
        check("mul_cycles", cnt, 32);
        check("mul_busy_bad", bad, 0);
        check("mul_result", result, 32'h0005_000F);
        check("mul_tag", out_tag, 13);
        check("mul_busy_done", busy, 0);
        tick;

        // Backpressure with a pending op
        out_ready = 1'b0;
        present(OP_ADD, 100, 23, 7);
        tick;
        check("bp_first", result, 123);
        present(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 8);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("bp_hold_result", result, 123);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        check("bp_new_result", result, 32'h0000_FF00);
        check("bp_new_tag", out_tag, 8);
        check("bp_new_valid", out_valid, 1);
        tick;

        // Reset in the middle of a MUL
        present(OP_MUL, $urandom, $urandom, 9);
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        check("mrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_result", result, 0);
        check("mrst_zero", zero, 0);
        check("mrst_tag", out_tag, 0);
        check("mrst_busy", busy, 0);
        rst = 1'b0;
        tick;
        check("mrst_idle", out_valid, 0);
        present(OP_ADD, 1, 1, 2);
        tick;
        in_valid = 1'b0;
        check("mrst_add_valid", out_valid, 1);
        check("mrst_add_result", result, 2);
        tick;

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 3));
            txn(rop, ra, rb, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 3-bit aluOp code plus two register operands and produces a registered result, zero flag and destination tag for writeback.
- Single-cycle ops complete with 1-cycle latency.
- MUL runs as an iterative shift-add over WIDTH cycles.
- Valid/ready handshakes on both sides let the stage stall decode and be stalled by writeback.

Parameters:
- WIDTH, 32, operand/result data width (≥2).
- TAG_W, 5, destination register tag width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_op  input  3  operation code from the ALU control decoder.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- in_tag  input  TAG_W  destination register tag.
- out_valid  output  1  result/zero/out_tag valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  MUL iteration in progress.

Behaviour:
- Op encoding, fixed:
  - 000 pass op_b
  - 001 ADD a+b
  - 010 SUB a−b
  - 011 SLT: signed a<b → 1, else 0
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MUL, low WIDTH bits of unsigned a*b
- Arithmetic: modulo 2^WIDTH; carries and overflow discarded; no exceptions.
- Reset (async, immediate): state=EMPTY; out_valid=0, result=0, zero=0, out_tag=0, busy=0. A reset mid-MUL aborts the operation; no partial result is ever presented.
- States:
  - EMPTY: no result held.
  - FULL: result held, out_valid=1.
  - MUL: iterating.
- in_ready = (state==EMPTY) | (state==FULL & out_ready); 0 in MUL. Combinational from state/out_ready only, never from in_valid.
- Accept = in_valid & in_ready.
  - Non-MUL: result, zero, out_tag registered at that edge; next state FULL, so out_valid is high the following cycle (latency 1).
  - MUL: latch multiplicand/multiplier/tag, clear accumulator, count=0; next state MUL; out_valid=0.
- MUL iteration: each cycle, if multiplier LSB is set, add multiplicand to accumulator; shift multiplicand left and multiplier right; count++. After exactly WIDTH iterations, load the accumulator into result, set zero, go to FULL. Latency = WIDTH+1 cycles from accept to out_valid.
- FULL & out_ready & !in_valid → EMPTY, out_valid=0 next cycle.
- FULL & out_ready & in_valid → result consumed and the new op accepted in the same cycle (back-to-back, throughput 1/cycle for non-MUL). A new MUL drops out_valid for WIDTH cycles.
- FULL & !out_ready: outputs held stable; in_ready=0; inputs ignored.
- in_valid with in_ready=0: no state change; upstream must hold inputs.
- zero always reflects the held result.
- Undefined alu_op values: none, since all 8 codes are defined.

Decomposition:
- Shared package (alu_pkg):
  - 3-bit op code constants OP_PASS..OP_MUL, shared with the ALU control decoder.
  - State encoding constants ST_EMPTY / ST_FULL / ST_MUL.
- One sub-module, alu_seq_mul: shift-add iterator with start / done / product ports, WIDTH parameter, owning the counter and accumulator.
- The combinational op mux stays in alu_exec_stage.

Test Plan:
- Reset, then ADD a=5, b=7, tag=3 with out_ready=1 → next cycle out_valid=1, result=12, zero=0, out_tag=3; following idle cycle out_valid=0.
- SUB a=9, b=9 → result=0, zero=1. SLT a=0xFFFFFFFF, b=1 → result=1. SLT a=1, b=0xFFFFFFFF → result=0.
- Back-to-back AND, OR, XOR on consecutive cycles with out_ready=1 → three results on three consecutive cycles; in_ready held 1 throughout.
- MUL a=0x0001_0003, b=0x0000_0005 → busy=1 and in_ready=0 for 32 cycles; out_valid asserts on cycle 33 with result=0x0005_000F.
- Backpressure: result held with out_ready=0 for 4 cycles while in_valid=1 → result stable, in_ready=0. When out_ready rises, the old result is taken and the pending op is accepted in the same cycle.
- Assert rst at MUL iteration 10 → outputs zero immediately, state EMPTY. A following ADD 1+1 returns 2 with latency 1.
